// File: rtl/rate_limiter_pkg.sv
// Shared types and helpers for the token-bucket AXI4-Stream rate limiter.
package rate_limiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_e;

  // Widest bus the byte counter is sized for; narrower tstrb is zero-extended.
  localparam int unsigned C_MAX_DATA_WIDTH = 1024;
  localparam int unsigned MAX_STRB_W       = C_MAX_DATA_WIDTH / 8;
  localparam int unsigned BYTE_CNT_W       = $clog2(MAX_STRB_W) + 1;

  function automatic logic [BYTE_CNT_W-1:0] popcount(input logic [MAX_STRB_W-1:0] v);
    logic [BYTE_CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < MAX_STRB_W; i++) begin
      c = c + {{(BYTE_CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/token_bucket.sv
// Interval counter, refill strobe and saturating signed byte bucket.
module token_bucket
  import rate_limiter_pkg::*;
#(
  parameter int unsigned C_TOKEN_WIDTH    = 32,
  parameter int unsigned C_INTERVAL_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sw_rst,
  input  logic [C_TOKEN_WIDTH-1:0]          cfg_tokens,
  input  logic [C_INTERVAL_WIDTH-1:0]       cfg_interval,
  input  logic [C_TOKEN_WIDTH-1:0]          cfg_bucket_max,
  input  logic [C_TOKEN_WIDTH:0]            debit,
  output logic signed [C_TOKEN_WIDTH:0]     bucket_level
);

  localparam int unsigned SW = C_TOKEN_WIDTH + 3;

  logic [C_INTERVAL_WIDTH-1:0] cnt_q, cnt_d, cnt_last;
  logic                        stb;
  logic signed [C_TOKEN_WIDTH:0] bucket_q, bucket_d;
  logic signed [SW-1:0] b_ext, r_ext, d_ext, ceil_ext, floor_ext, sum;

  always_comb begin
    cnt_last = (cfg_interval == '0) ? '0 : cfg_interval - 1'b1;
    stb      = (cnt_q == cnt_last);
    cnt_d    = stb ? '0 : cnt_q + 1'b1;

    // Three guard bits hold bucket + refill - debit without overflow.
    b_ext     = {{2{bucket_q[C_TOKEN_WIDTH]}}, bucket_q};
    r_ext     = stb ? {3'b000, cfg_tokens} : '0;
    d_ext     = {2'b00, debit};
    ceil_ext  = {3'b000, cfg_bucket_max};
    floor_ext = {3'b111, {C_TOKEN_WIDTH{1'b0}}};
    sum       = b_ext + r_ext - d_ext;

    if (sum > ceil_ext) begin
      bucket_d = {1'b0, cfg_bucket_max};
    end else if (sum < floor_ext) begin
      bucket_d = {1'b1, {C_TOKEN_WIDTH{1'b0}}};
    end else begin
      bucket_d = sum[C_TOKEN_WIDTH:0];
    end

    if (sw_rst) begin
      bucket_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      bucket_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      bucket_q <= bucket_d;
    end
  end

  assign bucket_level = bucket_q;

endmodule

// File: rtl/token_bucket_rate_limiter.sv
// Zero-latency AXI4-Stream token-bucket rate limiter gating only at packet boundaries.
// Define RATE_LIMITER_STATS_EN to build the packet and throttle counters.
module token_bucket_rate_limiter
  import rate_limiter_pkg::*;
#(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_TOKEN_WIDTH      = 32,
  parameter int unsigned C_INTERVAL_WIDTH   = 16
) (
  input  logic                            axi_aclk,
  input  logic                            axi_areset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  input  logic                            sw_rst,
  input  logic                            rate_lim_en,
  input  logic [C_TOKEN_WIDTH-1:0]        cfg_tokens,
  input  logic [C_INTERVAL_WIDTH-1:0]     cfg_interval,
  input  logic [C_TOKEN_WIDTH-1:0]        cfg_bucket_max,
  output logic signed [C_TOKEN_WIDTH:0]   status_tokens,
  output logic                            status_in_pkt,
  output logic [31:0]                     stat_pkt_count,
  output logic [31:0]                     stat_throttle_cycles
);

  localparam int unsigned STRB_W = C_AXIS_DATA_WIDTH / 8;

  state_e                      state_q, state_d;
  logic                        en_lat_q, en_lat_d;
  logic signed [C_TOKEN_WIDTH:0] bucket;
  logic                        bucket_pos;
  logic                        gate;
  logic                        accept;
  logic                        debit_en;
  logic [MAX_STRB_W-1:0]       strb_ext;
  logic [BYTE_CNT_W-1:0]       beat_bytes;
  logic [C_TOKEN_WIDTH:0]      debit;

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tstrb  = s_axis_tstrb;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tvalid = s_axis_tvalid & gate;
  assign s_axis_tready = m_axis_tready & gate;

  assign bucket_pos    = !bucket[C_TOKEN_WIDTH] && (bucket != '0);
  assign status_tokens = bucket;
  assign status_in_pkt = (state_q == PKT);

  always_comb begin
    gate = 1'b0;
    if (!axi_areset) begin
      gate = (state_q == PKT) || !rate_lim_en || bucket_pos;
    end
  end

  always_comb begin
    accept   = s_axis_tvalid & m_axis_tready & gate;
    strb_ext = '0;
    strb_ext[STRB_W-1:0] = s_axis_tstrb;
    beat_bytes = popcount(strb_ext);

    // The SOP beat is metered by the enable it latches, later beats by the latched value.
    debit_en = (state_q == IDLE) ? rate_lim_en : en_lat_q;
    debit    = (accept && debit_en) ?
               {{(C_TOKEN_WIDTH+1-BYTE_CNT_W){1'b0}}, beat_bytes} : '0;

    state_d  = state_q;
    en_lat_d = en_lat_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          en_lat_d = rate_lim_en;
          if (!s_axis_tlast) state_d = PKT;
        end
      end
      PKT: begin
        if (accept && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q  <= IDLE;
      en_lat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_lat_q <= en_lat_d;
    end
  end

  token_bucket #(
    .C_TOKEN_WIDTH   (C_TOKEN_WIDTH),
    .C_INTERVAL_WIDTH(C_INTERVAL_WIDTH)
  ) u_bucket (
    .clk           (axi_aclk),
    .rst           (axi_areset),
    .sw_rst        (sw_rst),
    .cfg_tokens    (cfg_tokens),
    .cfg_interval  (cfg_interval),
    .cfg_bucket_max(cfg_bucket_max),
    .debit         (debit),
    .bucket_level  (bucket)
  );

`ifdef RATE_LIMITER_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] thr_cnt_q, thr_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    thr_cnt_d = thr_cnt_q;
    if (accept && s_axis_tlast) pkt_cnt_d = pkt_cnt_q + 32'd1;
    if ((state_q == IDLE) && s_axis_tvalid && rate_lim_en && !bucket_pos) begin
      thr_cnt_d = thr_cnt_q + 32'd1;
    end
    if (sw_rst) begin
      pkt_cnt_d = '0;
      thr_cnt_d = '0;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      pkt_cnt_q <= '0;
      thr_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      thr_cnt_q <= thr_cnt_d;
    end
  end

  assign stat_pkt_count       = pkt_cnt_q;
  assign stat_throttle_cycles = thr_cnt_q;
`else
  assign stat_pkt_count       = '0;
  assign stat_throttle_cycles = '0;
`endif

endmodule

// File: tb/tb_token_bucket_rate_limiter.sv
// Directed self-checking bench for token_bucket_rate_limiter.
module tb_token_bucket_rate_limiter;

  localparam int unsigned DW = 256;
  localparam int unsigned UW = 128;
  localparam int unsigned TW = 32;
  localparam int unsigned IW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              axi_areset;
  logic [DW-1:0]     s_axis_tdata;
  logic [DW/8-1:0]   s_axis_tstrb;
  logic [UW-1:0]     s_axis_tuser;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic [DW-1:0]     m_axis_tdata;
  logic [DW/8-1:0]   m_axis_tstrb;
  logic [UW-1:0]     m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              sw_rst;
  logic              rate_lim_en;
  logic [TW-1:0]     cfg_tokens;
  logic [IW-1:0]     cfg_interval;
  logic [TW-1:0]     cfg_bucket_max;
  logic signed [TW:0] status_tokens;
  logic              status_in_pkt;
  logic [31:0]       stat_pkt_count;
  logic [31:0]       stat_throttle_cycles;

  token_bucket_rate_limiter #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(UW),
    .C_TOKEN_WIDTH     (TW),
    .C_INTERVAL_WIDTH  (IW)
  ) dut (
    .axi_aclk            (clk),
    .axi_areset          (axi_areset),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tstrb        (s_axis_tstrb),
    .s_axis_tuser        (s_axis_tuser),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tready       (s_axis_tready),
    .s_axis_tlast        (s_axis_tlast),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tstrb        (m_axis_tstrb),
    .m_axis_tuser        (m_axis_tuser),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tready       (m_axis_tready),
    .m_axis_tlast        (m_axis_tlast),
    .sw_rst              (sw_rst),
    .rate_lim_en         (rate_lim_en),
    .cfg_tokens          (cfg_tokens),
    .cfg_interval        (cfg_interval),
    .cfg_bucket_max      (cfg_bucket_max),
    .status_tokens       (status_tokens),
    .status_in_pkt       (status_in_pkt),
    .stat_pkt_count      (stat_pkt_count),
    .stat_throttle_cycles(stat_throttle_cycles)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int beats_out = 0;
  int pkt_id  = 0;
  logic [DW-1:0] exp_data;
  logic [UW-1:0] exp_user;
  logic signed [TW:0] tok_at_sop;
  logic [31:0] thr_at_sop;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!axi_areset && m_axis_tvalid && m_axis_tready) beats_out <= beats_out + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_tok(input string tag, input int exp);
    check_eq(tag, 256'(status_tokens), 256'(exp));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_beat(input int b, input int nb, input logic [31:0] strb);
    logic [31:0] word;
    word          = 32'hA500_0000 | 32'(pkt_id << 8) | 32'(b);
    exp_data      = {8{word}};
    exp_user      = {4{~word}};
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = exp_data;
    s_axis_tuser  = exp_user;
    s_axis_tstrb  = strb;
    s_axis_tlast  = (b == nb - 1);
  endtask

  task automatic end_pkt();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    pkt_id++;
  endtask

  task automatic wait_ready(output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_axis_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("handshake_bound", 256'(n < 200), 256'(1));
    acc_cyc = cyc;
  endtask

  task automatic send_pkt(input int nb, input logic [31:0] strb, output int sop_cyc, output int eop_cyc);
    int acc;
    sop_cyc = -1;
    eop_cyc = -1;
    for (int b = 0; b < nb; b++) begin
      set_beat(b, nb, strb);
      wait_ready(acc);
      if (b == 0) begin
        sop_cyc    = acc;
        tok_at_sop = status_tokens;
        thr_at_sop = stat_throttle_cycles;
      end
      eop_cyc = acc;
      check_eq("m_tvalid", 256'(m_axis_tvalid), 256'(1));
      check_eq("m_tdata", 256'(m_axis_tdata), 256'(exp_data));
      check_eq("m_tuser", 256'(m_axis_tuser), 256'(exp_user));
      check_eq("m_tstrb", 256'(m_axis_tstrb), 256'(strb));
      check_eq("m_tlast", 256'(m_axis_tlast), 256'(b == nb - 1));
      step(1);
    end
    end_pkt();
  endtask

  initial begin
    int s1, e1, s2, e2, s3, e3, rel, b0, acc;
    logic signed [TW:0] mx;

    axi_areset     = 1'b1;
    s_axis_tdata   = '0;
    s_axis_tstrb   = '0;
    s_axis_tuser   = '0;
    s_axis_tvalid  = 1'b1;
    s_axis_tlast   = 1'b0;
    m_axis_tready  = 1'b1;
    sw_rst         = 1'b0;
    rate_lim_en    = 1'b0;
    cfg_tokens     = 32'd32;
    cfg_interval   = 16'd10;
    cfg_bucket_max = 32'd64;
    step(3);

    // Reset state: gating forced off even with metering disabled.
    @(negedge clk);
    check_eq("rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
    check_eq("rst_s_tready", 256'(s_axis_tready), 256'(0));
    check_tok("rst_tokens", 0);
    check_eq("rst_in_pkt", 256'(status_in_pkt), 256'(0));
    check_eq("rst_pkt_cnt", 256'(stat_pkt_count), 256'(0));
    check_eq("rst_thr_cnt", 256'(stat_throttle_cycles), 256'(0));

    // Disabled: three back-to-back 4-beat packets pass untouched.
    @(posedge clk);
    #1;
    axi_areset    = 1'b0;
    s_axis_tvalid = 1'b0;
    b0 = beats_out;
    send_pkt(4, 32'hFFFF_FFFF, s1, e1);
    send_pkt(4, 32'hFFFF_FFFF, s2, e2);
    send_pkt(4, 32'hFFFF_FFFF, s3, e3);
    check_eq("dis_beats", 256'(beats_out - b0), 256'(12));
    check_eq("dis_span", 256'(e3 - s1), 256'(11));
    step(30);
    @(negedge clk);
    check_tok("dis_ceiling", 64);

    // Asynchronous reset clears the bucket before any clock edge.
    @(posedge clk);
    #1;
    axi_areset = 1'b1;
    #2;
    check_tok("async_rst_tok", 0);
    rate_lim_en = 1'b1;
    set_beat(0, 4, 32'hFFFF_FFFF);
    step(2);

    // Enabled: first SOP waits for the first refill, then deficit spacing.
    axi_areset = 1'b0;
    rel = cyc;
    send_pkt(4, 32'hFFFF_FFFF, s1, e1);
    check_eq("first_sop_delay", 256'(s1 - rel), 256'(10));
    check_eq("first_sop_tok", 256'(tok_at_sop), 256'(32));
`ifdef RATE_LIMITER_STATS_EN
    check_eq("first_sop_thr", 256'(thr_at_sop), 256'(10));
`else
    check_eq("first_sop_thr", 256'(thr_at_sop), 256'(0));
`endif
    @(negedge clk);
    check_tok("deficit", -96);
    send_pkt(4, 32'hFFFF_FFFF, s2, e2);
    check_eq("sop_gap", 256'(s2 - s1), 256'(40));
    check_eq("second_sop_tok", 256'(tok_at_sop), 256'(32));

    // Long idle: bucket reaches and holds the ceiling; then lower it.
    mx = status_tokens;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (status_tokens > mx) mx = status_tokens;
    end
    check_eq("idle_max", 256'(mx), 256'(64));
    check_tok("idle_level", 64);
    @(posedge clk);
    #1;
    cfg_bucket_max = 32'd16;
    @(negedge clk);
    check_tok("clamp_before", 64);
    step(1);
    @(negedge clk);
    check_tok("clamp_after", 16);

    // Refill and debit in the same cycle.
    @(posedge clk);
    #1;
    sw_rst         = 1'b1;
    cfg_tokens     = 32'd10;
    cfg_bucket_max = 32'd64;
    step(1);
    sw_rst = 1'b0;
    @(negedge clk);
    check_tok("swrst_clear", 0);
    step(10);
    cfg_tokens = 32'd32;
    @(negedge clk);
    check_tok("bucket_10", 10);
    step(9);
    set_beat(0, 1, 32'hFFFF_FFFF);
    @(negedge clk);
    check_eq("same_cyc_rdy1", 256'(s_axis_tready), 256'(1));
    step(1);
    end_pkt();
    @(negedge clk);
    check_tok("refill_and_32", 10);
    step(9);
    set_beat(0, 1, 32'h0000_000F);
    @(negedge clk);
    check_eq("same_cyc_rdy2", 256'(s_axis_tready), 256'(1));
    step(1);
    end_pkt();
    @(negedge clk);
    check_tok("refill_and_4", 38);

    // Downstream stall during beat 2.
    step(1);
    b0 = beats_out;
    set_beat(0, 4, 32'hFFFF_FFFF);
    @(negedge clk);
    check_eq("bp_beat0_rdy", 256'(s_axis_tready), 256'(1));
    step(1);
    set_beat(1, 4, 32'hFFFF_FFFF);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_tvalid_held", 256'(m_axis_tvalid), 256'(1));
      check_eq("bp_no_ready", 256'(s_axis_tready), 256'(0));
      check_eq("bp_in_pkt", 256'(status_in_pkt), 256'(1));
      check_tok("bp_tok_frozen", 6);
      step(1);
    end
    m_axis_tready = 1'b1;
    @(negedge clk);
    check_eq("bp_resume_rdy", 256'(s_axis_tready), 256'(1));
    check_eq("bp_resume_data", 256'(m_axis_tdata), 256'(exp_data));
    step(1);
    set_beat(2, 4, 32'hFFFF_FFFF);
    step(1);
    set_beat(3, 4, 32'hFFFF_FFFF);
    @(negedge clk);
    check_eq("bp_last_rdy", 256'(s_axis_tready), 256'(1));
    step(1);
    end_pkt();
    @(negedge clk);
    check_eq("bp_beats", 256'(beats_out - b0), 256'(4));
    check_eq("bp_idle", 256'(status_in_pkt), 256'(0));
    check_tok("bp_final_tok", -58);

    // Soft reset mid-packet: bucket clears, packet still completes.
    step(1);
    sw_rst = 1'b1;
    step(1);
    sw_rst = 1'b0;
    rel = cyc;
    b0 = beats_out;
    set_beat(0, 4, 32'hFFFF_FFFF);
    wait_ready(acc);
    check_eq("swrst_sop_delay", 256'(acc - rel), 256'(10));
    check_tok("swrst_sop_tok", 32);
`ifdef RATE_LIMITER_STATS_EN
    check_eq("swrst_thr", 256'(stat_throttle_cycles), 256'(10));
`else
    check_eq("swrst_thr", 256'(stat_throttle_cycles), 256'(0));
`endif
    step(1);
    set_beat(1, 4, 32'hFFFF_FFFF);
    sw_rst = 1'b1;
    @(negedge clk);
    check_eq("swrst_b1_rdy", 256'(s_axis_tready), 256'(1));
    step(1);
    sw_rst = 1'b0;
    set_beat(2, 4, 32'hFFFF_FFFF);
    @(negedge clk);
    check_tok("swrst_mid_tok", 0);
    check_eq("swrst_mid_in_pkt", 256'(status_in_pkt), 256'(1));
    check_eq("swrst_b2_rdy", 256'(s_axis_tready), 256'(1));
    step(1);
    set_beat(3, 4, 32'hFFFF_FFFF);
    @(negedge clk);
    check_eq("swrst_b3_rdy", 256'(s_axis_tready), 256'(1));
    check_eq("swrst_b3_last", 256'(m_axis_tlast), 256'(1));
    step(1);
    end_pkt();
    @(negedge clk);
    check_eq("swrst_beats", 256'(beats_out - b0), 256'(4));
    check_eq("swrst_idle", 256'(status_in_pkt), 256'(0));
    check_tok("swrst_end_tok", -64);
`ifdef RATE_LIMITER_STATS_EN
    check_eq("stat_pkt", 256'(stat_pkt_count), 256'(1));
`else
    check_eq("stat_pkt", 256'(stat_pkt_count), 256'(0));
`endif
    check_eq("stat_thr_end", 256'(stat_throttle_cycles), 256'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/token_bucket_rate_limiter.md
Name: token_bucket_rate_limiter

Overview:
Single-stream AXI4-Stream rate limiter that meters traffic with a byte-accurate token bucket, replacing the fixed-rate limiter. Data passes through with zero latency; only tvalid/tready are gated, and gating happens only at packet boundaries. Refill amount, refill interval and burst depth are software-configurable. The multi-port wrapper instantiates one per queue for any queue count.

Parameters:
C_AXIS_DATA_WIDTH, 256, tdata width (multiple of 8); tstrb is C_AXIS_DATA_WIDTH/8 bits
C_AXIS_TUSER_WIDTH, 128, tuser width
C_TOKEN_WIDTH, 32, width of the refill-amount and bucket-max configs (bytes)
C_INTERVAL_WIDTH, 16, width of the refill-interval config (cycles)

Ports:
axi_aclk  in  1  clock
axi_areset  in  1  asynchronous active-high reset
s_axis_tdata/tstrb/tuser/tvalid/tlast  in  per params  upstream stream
s_axis_tready  out  1  upstream ready
m_axis_tdata/tstrb/tuser/tvalid/tlast  out  per params  downstream stream
m_axis_tready  in  1  downstream ready
sw_rst  in  1  synchronous soft reset of the bucket and the interval counter
rate_lim_en  in  1  metering enable
cfg_tokens  in  C_TOKEN_WIDTH  bytes added per refill
cfg_interval  in  C_INTERVAL_WIDTH  cycles per refill (0 is treated as 1)
cfg_bucket_max  in  C_TOKEN_WIDTH  bucket ceiling (bytes)
status_tokens  out  C_TOKEN_WIDTH+1  signed bucket level
status_in_pkt  out  1  high while state is PKT
stat_pkt_count  out  32  packets forwarded
stat_throttle_cycles  out  32  cycles an SOP was held by the bucket

Behaviour:
- Reset (axi_areset high, asynchronous): state IDLE; bucket 0; interval counter 0; en_lat 0; stats 0. In reset, m_axis_tvalid=0 and s_axis_tready=0.
- Pass-through: tdata, tstrb, tuser and tlast are wired combinationally. m_axis_tvalid = s_axis_tvalid & gate. s_axis_tready = m_axis_tready & gate. Latency is 0; no beat is dropped or duplicated.
- Interval counter: counts 0 to max(cfg_interval,1)-1, then wraps. A refill strobe fires on the wrap cycle.
- Bucket is signed, C_TOKEN_WIDTH+1 bits. Update rule: next = bucket + (strobe ? cfg_tokens : 0) - debit.
  - The result saturates high at cfg_bucket_max and low at -2^C_TOKEN_WIDTH.
  - Refill and debit in the same cycle are both applied.
- debit = popcount(s_axis_tstrb) on every accepted beat (s_axis_tvalid & s_axis_tready) of a packet that started with en_lat=1; otherwise 0.
- FSM:
  - IDLE: gate = !rate_lim_en | (bucket > 0).
    - When an SOP beat is accepted, en_lat <= rate_lim_en.
    - If that beat has tlast=0, go to PKT; if tlast=1 (single-beat packet), stay in IDLE.
  - PKT: gate = 1. Beat accepted with tlast=1 goes to IDLE.
- Enable changes take effect only at the next SOP. The bucket may go negative mid-packet (deficit accounting); the following SOP waits until bucket > 0.
- While disabled: the bucket still refills to the ceiling; packets started while disabled are not debited.
- cfg_bucket_max lowered below the current level: the bucket clamps to the new ceiling on the next cycle.
- sw_rst=1: bucket <= 0 and interval counter <= 0, with priority over refill and debit. The FSM is unaffected, so an in-flight packet completes intact.
- Backpressure: while m_axis_tready=0 there is no debit, and tvalid is held per AXIS rules.

Optional Feature:
Macro RATE_LIMITER_STATS_EN.
- Defined:
  - stat_pkt_count increments on every accepted tlast beat.
  - stat_throttle_cycles increments each cycle in IDLE with s_axis_tvalid=1, rate_lim_en=1 and bucket <= 0.
  - Both wrap at 2^32; both clear on axi_areset and sw_rst.
- Undefined: both outputs are tied to 0 and no counters are synthesised.

Decomposition:
- Package rate_limiter_pkg:
  - FSM state enum (IDLE, PKT).
  - popcount function.
  - Localparam for the byte-count width: $clog2(C_AXIS_DATA_WIDTH/8)+1.
- Sub-module token_bucket: interval counter, refill strobe, saturating signed bucket. Inputs are debit, sw_rst and the configs; output is the bucket level.
- The FSM and gating stay in the top level.

Test Plan:
- rate_lim_en=0, three 4-beat packets back-to-back, m_axis_tready=1: 12 beats out in 12 consecutive cycles; data/tuser/tlast identical to input; no debit (status_tokens ends at the configured ceiling).
- rate_lim_en=1, cfg_tokens=32, cfg_interval=10, cfg_bucket_max=64, 256-bit bus with full tstrb, 4-beat packets:
  - First SOP is accepted at cycle 10 after reset release.
  - Bucket ends at -96; next SOP is held until 4 refills (bucket=32), i.e. a 40-cycle gap.
- Same config, idle 1000 cycles: status_tokens=64, never above. Then cfg_bucket_max=16: status_tokens=16 one cycle later.
- Bucket=10; refill of 32 and a 32-byte beat in the same cycle: bucket=10. Repeat with tstrb=0x0000000F: bucket=38.
- m_axis_tready low for 5 cycles during beat 2: no beat lost, m_axis_tvalid held high, bucket unchanged during the stall.
- sw_rst pulsed during beat 2 of a 4-beat packet: bucket=0 and the packet completes all 4 beats. With RATE_LIMITER_STATS_EN defined:
  - stat_pkt_count=1.
  - stat_throttle_cycles counts the hold cycles until the first refill.
